linear_stream_engine: RTL

Streaming successor to the fixed-width multiplier datapath. It computes one quantised linear-layer output per sample for `NUM_FEATURES` samples in parallel, with weights shared across samples. Dot products are accumulated over a runtime-selected number of `N`-wide beats, then zero-point corrected, biased, requantised and saturated to `PRECISION` bits. It sits between the feature/weight streaming front-end and the activation write-back, and replaces the free-running `ce` flow with valid/ready handshakes on both sides.

---
 rtl/linear_stream_engine_if.sv | 30 +++
 rtl/linear_stream_engine.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/linear_stream_engine_if.sv
// Handshaked bundle for linear_stream_engine.
// Carries the input beat stream (weights and features) and the result stream.
interface linear_stream_engine_if #(
  parameter int unsigned NUM_FEATURES   = 2,
  parameter int unsigned N              = 16,
  parameter int unsigned PRECISION      = 8,
  parameter int unsigned BIAS_PRECISION = 32,
  parameter int unsigned BEAT_W         = 8
);
  logic [BEAT_W-1:0]                             num_beats;
  logic [BIAS_PRECISION-1:0]                     bias;
  logic                                          in_valid;
  logic                                          in_ready;
  logic [N-1:0][PRECISION-1:0]                   weights_in;
  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] features;
  logic                                          out_valid;
  logic                                          out_ready;
  logic [NUM_FEATURES-1:0][PRECISION-1:0]        out;
  logic [NUM_FEATURES-1:0][BIAS_PRECISION-1:0]   long_out;

  modport master (
    output num_beats, bias, in_valid, weights_in, features, out_ready,
    input  in_ready, out_valid, out, long_out
  );

  modport slave (
    input  num_beats, bias, in_valid, weights_in, features, out_ready,
    output in_ready, out_valid, out, long_out
  );
endinterface

// File: rtl/linear_stream_engine.sv
// Quantised linear layer over NUM_FEATURES samples sharing one weight stream: accumulates
// N-wide beats, applies weight zero point and bias, then requantises with saturation.
module linear_stream_engine #(
  parameter int unsigned NUM_FEATURES   = 2,
  parameter int unsigned N              = 16,
  parameter int unsigned PRECISION      = 8,
  parameter int unsigned BIAS_PRECISION = 32,
  parameter int unsigned BEAT_W         = 8,
  parameter int unsigned Z_WEIGHTS      = 5,
  parameter int          Z_OUT          = 0,
  parameter logic [30:0] M_MUL          = 31'd1073741824,
  parameter int unsigned SHIFT          = 0
) (
  input logic                   clk,
  input logic                   rst,
  linear_stream_engine_if.slave bus
);
  localparam int unsigned PW = 64;
  localparam logic signed [PW-1:0] OUT_MAX = (64'sd1 <<< PRECISION) - 64'sd1;
  localparam logic signed [PW-1:0] RND     = 64'sd1 <<< (30 + SHIFT);

  typedef enum logic [2:0] {IDLE, ACC, CORR, SCALE, OUT} state_t;
  typedef logic [NUM_FEATURES-1:0][BIAS_PRECISION-1:0] lane_word_t;

  state_t                                 state_q, state_d;
  logic [BEAT_W-1:0]                      cnt_q, cnt_d;
  logic [BEAT_W-1:0]                      nb_q, nb_d;
  logic [BEAT_W-1:0]                      nb_eff;
  logic [BIAS_PRECISION-1:0]              bias_q, bias_d;
  lane_word_t                             acc_q, acc_d;
  lane_word_t                             ai_q, ai_d;
  lane_word_t                             corr_q, corr_d;
  lane_word_t                             long_q, long_d;
  lane_word_t                             beat_fw, beat_f;
  logic [NUM_FEATURES-1:0][PRECISION-1:0] out_q, out_d;
  logic                                   in_ready_q, in_ready_d;
  logic                                   out_valid_q, out_valid_d;
  logic                                   in_hs, out_hs;

  // Round-half-up arithmetic rescale followed by output zero point and saturation.
  function automatic logic [PRECISION-1:0] requant(input logic [BIAS_PRECISION-1:0] c);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] s;
    p = PW'($signed(c)) * $signed(PW'(M_MUL));
    s = ((p + RND) >>> (31 + SHIFT)) + PW'(Z_OUT);
    if (s < 64'sd0) begin
      requant = '0;
    end else if (s > OUT_MAX) begin
      requant = '1;
    end else begin
      requant = s[PRECISION-1:0];
    end
  endfunction

  assign in_hs  = bus.in_valid & in_ready_q;
  assign out_hs = out_valid_q & bus.out_ready;
  assign nb_eff = (bus.num_beats == '0) ? BEAT_W'(1) : bus.num_beats;

  // Per-lane dot product and feature sum of the current beat.
  always_comb begin
    beat_fw = '0;
    beat_f  = '0;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      for (int j = 0; j < N; j++) begin
        beat_fw[i] = beat_fw[i] + BIAS_PRECISION'(bus.features[i][j]) *
                                  BIAS_PRECISION'(bus.weights_in[j]);
        beat_f[i]  = beat_f[i] + BIAS_PRECISION'(bus.features[i][j]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nb_q        <= '0;
      bias_q      <= '0;
      acc_q       <= '0;
      ai_q        <= '0;
      corr_q      <= '0;
      long_q      <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nb_q        <= nb_d;
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      ai_q        <= ai_d;
      corr_q      <= corr_d;
      long_q      <= long_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // out_valid rises one cycle after entering OUT so a result costs num_beats+3 plus the handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nb_d        = nb_q;
    bias_d      = bias_q;
    acc_d       = acc_q;
    ai_d        = ai_q;
    corr_d      = corr_q;
    long_d      = long_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          nb_d    = nb_eff;
          bias_d  = bus.bias;
          acc_d   = beat_fw;
          ai_d    = beat_f;
          cnt_d   = BEAT_W'(1);
          state_d = (nb_eff == BEAT_W'(1)) ? CORR : ACC;
        end
      end
      ACC: begin
        if (in_hs) begin
          for (int i = 0; i < NUM_FEATURES; i++) begin
            acc_d[i] = acc_q[i] + beat_fw[i];
            ai_d[i]  = ai_q[i] + beat_f[i];
          end
          cnt_d = cnt_q + BEAT_W'(1);
          if (cnt_d == nb_q) begin
            state_d = CORR;
          end
        end
      end
      CORR: begin
        for (int i = 0; i < NUM_FEATURES; i++) begin
          corr_d[i] = acc_q[i] - BIAS_PRECISION'(Z_WEIGHTS) * ai_q[i] + bias_q;
        end
        state_d = SCALE;
      end
      SCALE: begin
        for (int i = 0; i < NUM_FEATURES; i++) begin
          out_d[i] = requant(corr_q[i]);
        end
        long_d  = corr_q;
        state_d = OUT;
      end
      OUT: begin
        out_valid_d = ~out_hs;
        if (out_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE) || (state_d == ACC);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.long_out  = long_q;
endmodule
